// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time from instruction
// memory, holds it for decode, and steers the external program counter.
// At most one memory request is ever outstanding; redirects squash the
// in-flight fetch, and a response still in flight is drained before the
// next request goes out.
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    // program counter interface
    input  logic [15:0] pc,
    output logic        pc_ctrl,
    output logic [15:0] pc_next,
    // redirect from a later stage
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    // instruction memory
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    // decode handshake
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,  // issuing a request at pc
        WAIT  = 2'd1,  // granted, waiting for the response
        HOLD  = 2'd2,  // word buffered, offering it to decode
        DRAIN = 2'd3   // squashed request, swallowing its response
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc_q, buf_pc_d;

    // State register and fetch buffers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            req_pc_q    <= 16'h0000;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Handshake outputs; reset forces the idle values regardless of state.
    always_comb begin
        imem_addr = pc;
        imem_req  = (state_q == REQ) && !redirect && !rst;
        id_valid  = (state_q == HOLD) && !redirect && !rst;
        id_instr  = ((state_q == HOLD) && !rst) ? buf_instr_q : NOP_INSTR;
        id_pc     = rst ? 16'h0000 : buf_pc_q;
    end

    // Program counter steering: redirect wins, an accepted request advances
    // the PC by 4, anything else reloads the current PC so it holds.
    always_comb begin
        pc_ctrl = 1'b1;
        pc_next = pc;
        if (rst) begin
            pc_next = 16'h0000;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (imem_req && imem_gnt) begin
            pc_ctrl = 1'b0;
        end
    end

    // Next-state logic. A response arriving in REQ or HOLD cannot belong
    // to a live request and is ignored; grants only matter in REQ.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        unique case (state_q)
            REQ: begin
                if (imem_gnt && !redirect) begin
                    req_pc_d = pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid && !redirect) begin
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = req_pc_q;
                    state_d     = HOLD;
                end else if (imem_rvalid) begin
                    state_d = REQ;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect || (id_valid && id_ready)) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be as follows, one per line:
  NOP_INSTR, 32'h0000_0013, value driven on id_instr whenever no instruction is held.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on its rising edge.
  rst  input  1  synchronous, active-high reset.
  pc  input  16  current PC from programcounter.
  pc_ctrl  output  1  drives programcounter ctrl (1 = load pc_next, 0 = PC advances by 4).
  pc_next  output  16  drives programcounter pc_next.
  redirect  input  1  branch/jump redirect from a later stage; squashes fetch.
  redirect_pc  input  16  redirect target address.
  imem_req  output  1  instruction-memory request.
  imem_addr  output  16  request address.
  imem_gnt  input  1  memory accepts the request this cycle.
  imem_rvalid  input  1  response data valid.
  imem_rdata  input  32  response instruction word.
  id_valid  output  1  instruction available to decode.
  id_instr  output  32  instruction word to decode.
  id_pc  output  16  address of id_instr.
  id_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-003 The FSM SHALL have the states REQ, WAIT, HOLD and DRAIN, with exactly one state active at a time.
REQ-004 PC control: redirect=1 SHALL give pc_ctrl=1 and pc_next=redirect_pc, in any state.
  - Otherwise, imem_req & imem_gnt SHALL give pc_ctrl=0 (PC advances by 4).
  - Otherwise, the block SHALL drive pc_ctrl=1 and pc_next=pc (PC holds).
REQ-005 imem_req SHALL be (state==REQ) & !redirect; imem_addr SHALL equal pc combinationally.
REQ-006 REQ: on imem_gnt & !redirect, the block SHALL capture req_pc<=pc and go to WAIT; otherwise it SHALL stay in REQ.
REQ-007 WAIT: on imem_rvalid & !redirect, the block SHALL capture buf_instr<=imem_rdata and buf_pc<=req_pc, then go to HOLD.
  - imem_rvalid & redirect: discard the data, go to REQ.
  - redirect & !imem_rvalid: go to DRAIN.
  - Otherwise stay in WAIT.
REQ-008 DRAIN: on imem_rvalid the block SHALL discard the data and go to REQ; otherwise it SHALL stay in DRAIN, including when a further redirect arrives.
REQ-009 HOLD: id_valid SHALL be (state==HOLD) & !redirect; id_instr=buf_instr and id_pc=buf_pc SHALL stay stable while id_valid is high and id_ready is low.
REQ-010 HOLD: the block SHALL go to REQ on redirect (instruction squashed, no transfer counted) or on id_valid & id_ready; otherwise it SHALL stay in HOLD.
REQ-011 When not in HOLD, id_valid SHALL be 0 and id_instr SHALL be NOP_INSTR.
REQ-012 imem_gnt SHALL be ignored outside REQ; imem_rvalid SHALL be ignored in REQ and HOLD.
REQ-013 Best-case throughput SHALL be one instruction per 3 cycles (REQ->WAIT->HOLD) with gnt in the request cycle, rvalid one cycle later and id_ready high.
REQ-014 At most one memory request SHALL be outstanding at any time.

Reset
REQ-015 While rst=1, on the next clock edge: state SHALL become REQ, buf_instr NOP_INSTR, buf_pc 0, req_pc 0.
REQ-016 While rst=1, outputs SHALL be: imem_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, pc_ctrl=1, pc_next=0.
REQ-017 rst asserted in WAIT or DRAIN SHALL discard the outstanding response; any later imem_rvalid SHALL be ignored until a new grant.

Verification
REQ-018 Reset then pc=0, gnt=1, rvalid the next cycle with rdata=32'h00500093, id_ready=1 -> id_valid in cycle 3 with id_pc=0x0000, id_instr=32'h00500093; the next request has imem_addr=0x0004.
REQ-019 gnt held 0 for 5 cycles -> imem_req stays 1, pc_ctrl=1, pc_next=pc; the PC holds at 0x0000 throughout.
REQ-020 HOLD with id_ready=0 for 4 cycles -> id_valid=1, id_instr and id_pc unchanged; id_ready=1 -> transfer, then return to REQ.
REQ-021 Redirect to 0x0100 while in WAIT, rvalid 2 cycles later -> DRAIN, data discarded, id_valid never asserted; the next imem_addr=0x0100.
REQ-022 Redirect in the same cycle as imem_rvalid -> no HOLD; pc_next=redirect_pc with pc_ctrl=1; the next request targets the redirect address.
REQ-023 rst asserted while in HOLD with id_valid=1 -> id_valid=0 and id_instr=NOP_INSTR from the next cycle; the first request after reset has imem_addr=0x0000.
